// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enc_pkg
//  Description : Shared widths and state encodings for the 16-to-4 one-hot
//                encoder/checker and the decoder checker that reuses it.
//  Revision    : 1.0  initial release
// ============================================================================
package enc_pkg;

  localparam int ENC_IN_W      = 16;
  localparam int ENC_CODE_W    = 4;
  localparam int ENC_CNT_W_DEF = 8;

  // Output buffer occupancy: EMPTY means out_valid=0, FULL means out_valid=1.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } enc_state_e;

endpackage : enc_pkg
`default_nettype wire

// File: rtl/enc_prio_16x4.sv
`default_nettype none
// ============================================================================
//  Module      : enc_prio_16x4
//  Description : Purely combinational 16-to-4 priority encoder. The highest
//                set bit wins; err flags any word that is not strictly one-hot
//                (no bits set, or more than one bit set).
//  Revision    : 1.0  initial release
// ============================================================================
module enc_prio_16x4
  import enc_pkg::*;
(
  input  logic [ENC_IN_W-1:0]   d_i,
  output logic [ENC_CODE_W-1:0] code_o,
  output logic                  err_o
);

  logic w_nonzero;
  logic w_multi;

  // Scan upward so the last match, i.e. the highest set bit, sets the code.
  always_comb begin
    code_o = '0;
    for (int i = 0; i < ENC_IN_W; i++) begin
      if (d_i[i]) begin
        code_o = ENC_CODE_W'(i);
      end
    end
  end

  // x & (x-1) clears the lowest set bit; anything left means two or more bits.
  always_comb begin
    w_nonzero = |d_i;
    w_multi   = |(d_i & (d_i - ENC_IN_W'(1)));
    err_o     = !w_nonzero || w_multi;
  end

endmodule : enc_prio_16x4
`default_nettype wire

// File: rtl/enc_16x4_chk.sv
`default_nettype none
// ============================================================================
//  Module      : enc_16x4_chk
//  Description : Registered 16-to-4 priority encoder with one-hot integrity
//                checking behind a single valid/ready register stage, plus a
//                saturating count of accepted non-one-hot words.
//                Build option: define ENC_FAULT_CNT_EN to build the fault
//                counter; otherwise fault_cnt reads 0 and cnt_clr is ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module enc_16x4_chk
  import enc_pkg::*;
#(
  parameter int CNT_W = ENC_CNT_W_DEF
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ENC_IN_W-1:0]   d,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ENC_CODE_W-1:0] code,
  output logic                  err,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      fault_cnt
);

  // The input width is fixed by the encoder; it is deliberately not a parameter.
  localparam int WIDTH = ENC_IN_W;

  enc_state_e                state_q, state_d;
  logic [ENC_CODE_W-1:0]     code_q;
  logic                      err_q;
  logic [ENC_CODE_W-1:0]     w_code;
  logic                      w_err;
  logic                      w_accept;
  logic [WIDTH-1:0]          w_d;

  assign w_d = d;

  enc_prio_16x4 u_prio (
    .d_i    (w_d),
    .code_o (w_code),
    .err_o  (w_err)
  );

  // Single stage, no skid: a slot is free when empty or being drained now.
  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign code      = code_q;
  assign err       = err_q;

  // Occupancy register; async reset discards any buffered result at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy: an accept always fills, a drain without accept empties.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (w_accept) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (w_accept)       state_d = ST_FULL;
        else if (out_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Result payload loads only on accept, so d is never observed otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q <= '0;
      err_q  <= 1'b0;
    end else if (w_accept) begin
      code_q <= w_code;
      err_q  <= w_err;
    end
  end

`ifdef ENC_FAULT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear has priority over a coincident error; counting stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (w_accept && w_err && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Fault counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fault_cnt = cnt_q;
`else
  logic w_unused_cnt_clr;

  assign w_unused_cnt_clr = cnt_clr;
  assign fault_cnt        = '0;
`endif

endmodule : enc_16x4_chk
`default_nettype wire

// File: tb/tb_enc_16x4_chk.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enc_16x4_chk
//  Description : Directed self-checking bench for enc_16x4_chk with
//                hand-computed expected values. Counter expectations follow
//                whether ENC_FAULT_CNT_EN is defined for the build.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_enc_16x4_chk;

`ifdef ENC_FAULT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  code;
  logic        err;
  logic        out_valid;
  logic        out_ready;
  logic        cnt_clr;
  logic [7:0]  fault_cnt;

  int n_pass  = 0;
  int n_total = 0;

  enc_16x4_chk #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .code      (code),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt_clr   (cnt_clr),
    .fault_cnt (fault_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; d = '0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    #1;
    chk_eq("rst_out_valid", out_valid, 0);
    chk_eq("rst_code", code, 0);
    chk_eq("rst_err", err, 0);
    chk_eq("rst_cnt", fault_cnt, 0);
    chk_eq("rst_in_ready", in_ready, 1);
    step(); step();
    rst = 1'b0;

    // Single accept of bit 10.
    d = 16'h0400; in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk_eq("t1_out_valid", out_valid, 1);
    chk_eq("t1_code", code, 10);
    chk_eq("t1_err", err, 0);
    chk_eq("t1_cnt", fault_cnt, 0);
    in_valid = 1'b0; d = 'x;
    step();
    chk_eq("t1_drain", out_valid, 0);

    // Back-to-back one-hot sweep.
    for (int i = 0; i < 16; i++) begin
      d = 16'(1) << i; in_valid = 1'b1;
      chk_eq("sweep_in_ready", in_ready, 1);
      step();
      chk_eq("sweep_valid", out_valid, 1);
      chk_eq("sweep_code", code, i);
      chk_eq("sweep_err", err, 0);
    end
    in_valid = 1'b0;
    step();
    chk_eq("sweep_cnt", fault_cnt, 0);

    // Non-one-hot words.
    d = 16'h0000; in_valid = 1'b1;
    step();
    chk_eq("zero_code", code, 0);
    chk_eq("zero_err", err, 1);
    d = 16'h8001;
    step();
    chk_eq("8001_code", code, 15);
    chk_eq("8001_err", err, 1);
    chk_eq("cnt_after2", fault_cnt, exp_cnt(2));
    d = 16'h0081;
    step();
    chk_eq("0081_code", code, 7);
    chk_eq("0081_err", err, 1);
    chk_eq("cnt_after3", fault_cnt, exp_cnt(3));
    in_valid = 1'b0;
    step();

    // Backpressure: result holds while d changes.
    out_ready = 1'b0; d = 16'h0020; in_valid = 1'b1;
    step();
    chk_eq("bp_code0", code, 5);
    for (int k = 0; k < 5; k++) begin
      d = 16'hFFFF ^ 16'(k * 16'h1111);
      #1;
      chk_eq("bp_in_ready", in_ready, 0);
      step();
      chk_eq("bp_valid", out_valid, 1);
      chk_eq("bp_code", code, 5);
      chk_eq("bp_err", err, 0);
    end
    chk_eq("bp_cnt", fault_cnt, exp_cnt(3));
    out_ready = 1'b1; d = 16'h0100;
    #1;
    chk_eq("bp_release_ready", in_ready, 1);
    step();
    chk_eq("bp_next_valid", out_valid, 1);
    chk_eq("bp_next_code", code, 8);
    chk_eq("bp_next_err", err, 0);
    in_valid = 1'b0;
    step();
    chk_eq("bp_empty", out_valid, 0);

    // Saturation of the fault counter.
    d = 16'h0000; in_valid = 1'b1;
    for (int k = 0; k < 300; k++) step();
    chk_eq("sat_cnt", fault_cnt, exp_cnt(255));
    step();
    chk_eq("sat_hold", fault_cnt, exp_cnt(255));
    cnt_clr = 1'b1;
    step();
    chk_eq("clr_with_err", fault_cnt, 0);
    cnt_clr = 1'b0;
    step();
    chk_eq("cnt_after_clr", fault_cnt, exp_cnt(1));
    in_valid = 1'b0;
    step();

    // Asynchronous reset while FULL and stalled.
    out_ready = 1'b0; d = 16'h0003; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_eq("pre_rst_valid", out_valid, 1);
    chk_eq("pre_rst_code", code, 1);
    chk_eq("pre_rst_err", err, 1);
    chk_eq("pre_rst_cnt", fault_cnt, exp_cnt(2));
    #2 rst = 1'b1;
    #1;
    chk_eq("arst_valid", out_valid, 0);
    chk_eq("arst_code", code, 0);
    chk_eq("arst_err", err, 0);
    chk_eq("arst_cnt", fault_cnt, 0);
    chk_eq("arst_in_ready", in_ready, 1);
    step();
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_enc_16x4_chk
`default_nettype wire

// File: doc/enc_16x4_chk.md
# enc_16x4_chk

Registered 16-to-4 priority encoder with one-hot integrity checking: the inverse of the team's 4x16 decoder and the receive side for decoder fault-injection experiments. Accepts a 16-bit decoded word over a valid/ready handshake, returns its 4-bit index one cycle later, and flags words that are not strictly one-hot. Used in the decoder test harness to close the loop and count stuck-at faults observed on decoder outputs.

## Interface
- WIDTH, 16: decoded input width; fixed at 16 and not overridable.
- CNT_W, 8: width of the fault counter.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- d  input  16  decoded word; bit i set means index i.
- in_valid  input  1  d is valid this cycle.
- in_ready  output  1  block accepts d this cycle.
- code  output  4  encoded index; highest set bit wins.
- err  output  1  word held on code was not one-hot (zero bits set or more than one bit set).
- out_valid  output  1  code/err hold a result.
- out_ready  input  1  consumer takes the result.
- cnt_clr  input  1  synchronous clear of fault_cnt.
- fault_cnt  output  CNT_W  saturating count of accepted non-one-hot words.

## Operation
- Two-state output buffer: EMPTY (out_valid=0) and FULL (out_valid=1).
- in_ready = !out_valid | out_ready (single register stage, no skid buffer).
- Accept happens when in_valid & in_ready. On accept, register code = index of the highest set bit of d, err = (popcount(d) != 1), and enter FULL.
- When d is all zeros, code = 0 and err = 1.
- When d has multiple bits set, for example 16'h0081, code = 7 and err = 1.
- FULL with out_ready=1 and no accept: go to EMPTY. FULL with out_ready=1 and an accept: stay FULL and load the new result (back-to-back throughput of 1 per cycle).
- FULL with out_ready=0: code and err hold, and in_ready=0.
- fault_cnt increments by 1 on each accept whose err=1. It saturates at 2^CNT_W−1 and does not wrap.
- When cnt_clr=1, fault_cnt loads 0 and any error accepted in the same cycle is not counted.
- d is ignored when not accepted. X on d while in_valid=0 must not propagate.

## Timing
- Reset values: out_valid=0, code=0, err=0, fault_cnt=0, state EMPTY. in_ready therefore reads 1.
- Reset asserted mid-operation discards the buffered result immediately, without waiting for a clock edge.
- Latency: accept at edge N makes the result visible after edge N, and it may be consumed at edge N+1.
- fault_cnt updates on the same edge as the accept that caused it.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from d or in_valid to any output.

## Configuration
- ENC_FAULT_CNT_EN defined: fault_cnt and cnt_clr behave as described above.
- ENC_FAULT_CNT_EN undefined: the counter register is not built, fault_cnt is tied to 0, and cnt_clr is ignored. err is still produced.

## Structure
- Shared package/header enc_pkg holds:
  - localparams ENC_IN_W=16, ENC_CODE_W=4, and the default CNT_W;
  - state encodings ST_EMPTY=1'b0 and ST_FULL=1'b1.
- One combinational sub-module, enc_prio_16x4, maps d to {code, err}. It is reusable by the decoder checker.
- Top level holds:
  - the handshake register stage;
  - the state bit;
  - the saturating counter.

## Test plan
- Reset, then apply d=16'h0400 with in_valid=1 for one cycle and out_ready=1 → next cycle out_valid=1, code=10, err=0; fault_cnt stays 0.
- Sweep d=1<<i for i=0..15 back-to-back with out_ready=1 → codes 0..15 on consecutive cycles, err=0 throughout, in_ready=1 throughout.
- Apply d=16'h0000, then d=16'h8001 → first result code=0 with err=1, second code=15 with err=1; fault_cnt=2.
- Hold out_ready=0 after one accept → in_ready=0, and code/err remain stable for 5 cycles while d changes. Raise out_ready → result consumed, next word accepted on the same edge.
- Feed 300 zero words with ENC_FAULT_CNT_EN defined → fault_cnt=255 and does not wrap. Assert cnt_clr together with an error accept → fault_cnt=0.
- Assert rst asynchronously while FULL with out_ready=0 → out_valid, code, err and fault_cnt go to 0 before the next clock edge, and in_ready=1.
